// File: rtl/edid_pkg.sv
// Shared definitions for the EDID RAM arbiter: FSM states, block geometry and checksum helper.
package edid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_RD,
    S_CS_WAIT,
    S_CS_WR,
    S_DONE
  } edid_state_t;

  localparam int unsigned EDID_BLK_BYTES = 128;
  localparam int unsigned EDID_CSUM_OFS  = 127;

  // Value that makes the 128-byte block sum to 0 mod 256.
  function automatic logic [7:0] edid_csum(input logic [7:0] sum);
    return 8'(9'h100 - {1'b0, sum});
  endfunction

endpackage

// File: rtl/edid_ram_arbiter_if.sv
// I2C slave, host loader and RAM port signals of the EDID RAM arbiter.
// slave = arbiter side, master = surrounding wrapper / bench side.
interface edid_ram_arbiter_if #(
  parameter int unsigned P_AW = 8
);
  logic            i2c_wr_de;
  logic [P_AW-1:0] i2c_wr_addr;
  logic [7:0]      i2c_wr_data;
  logic            i2c_rd_de;
  logic [P_AW-1:0] i2c_rd_addr;
  logic [7:0]      i2c_rd_data;
  logic            wp;
  logic            wp_viol;
  logic            host_req;
  logic            host_we;
  logic [P_AW-1:0] host_addr;
  logic [7:0]      host_wdata;
  logic            host_ack;
  logic            host_rvalid;
  logic [7:0]      host_rdata;
  logic            host_lock;
  logic            host_commit;
  logic            ram_we;
  logic [P_AW-1:0] ram_addr;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram_rdata;
  logic            hpd;
  logic            busy;

  modport slave (
    input  i2c_wr_de, i2c_wr_addr, i2c_wr_data, i2c_rd_de, i2c_rd_addr, wp,
           host_req, host_we, host_addr, host_wdata, host_lock, host_commit, ram_rdata,
    output i2c_rd_data, wp_viol, host_ack, host_rvalid, host_rdata,
           ram_we, ram_addr, ram_wdata, hpd, busy
  );

  modport master (
    output i2c_wr_de, i2c_wr_addr, i2c_wr_data, i2c_rd_de, i2c_rd_addr, wp,
           host_req, host_we, host_addr, host_wdata, host_lock, host_commit, ram_rdata,
    input  i2c_rd_data, wp_viol, host_ack, host_rvalid, host_rdata,
           ram_we, ram_addr, ram_wdata, hpd, busy
  );
endinterface

// File: rtl/edid_csum_engine.sv
// Checksum engine: byte index, read-issued flag, wrap-around accumulator, checksum byte value.
// Only present when EDID_CSUM_EN is defined.
`ifdef EDID_CSUM_EN
module edid_csum_engine
  import edid_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       rd_issue,
  input  logic [7:0] rd_data,
  output logic [6:0] idx,
  output logic       last,
  output logic [7:0] wr_val
);
  logic       issued;
  logic [7:0] sum;

  // RAM data lags the address by one cycle, so the add is qualified by last cycle's issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      issued <= 1'b0;
      sum    <= '0;
    end else begin
      issued <= rd_issue;
      if (clear) begin
        idx <= '0;
        sum <= '0;
      end else begin
        if (rd_issue) idx <= idx + 7'd1;
        if (issued)   sum <= sum + rd_data;
      end
    end
  end

  assign last   = (idx == 7'(EDID_CSUM_OFS - 1));
  assign wr_val = edid_csum(sum);
endmodule
`endif

// File: rtl/edid_ram_arbiter.sv
// EDID RAM arbiter: I2C write > I2C read > checksum engine > host on the single RAM port,
// plus commit/HPD sequencing. Define EDID_CSUM_EN to regenerate block checksums on commit.
module edid_ram_arbiter
  import edid_pkg::*;
#(
  parameter int unsigned P_AW     = 8,
  parameter int unsigned P_BLOCKS = 2
) (
  input logic               i_local_clk,
  input logic               i_rst,
  edid_ram_arbiter_if.slave bus
);
  if (P_BLOCKS * EDID_BLK_BYTES > (1 << P_AW)) begin : g_cfg_check
    $error("P_BLOCKS blocks do not fit in a 2**P_AW byte RAM");
  end

  edid_state_t state;
  logic slot_free, commit_take, host_grant;
  logic hpd, rvalid, lock_q, busy_q;

  assign slot_free   = !bus.i2c_wr_de && !bus.i2c_rd_de;
  assign commit_take = (state == S_IDLE) && bus.host_commit && !busy_q && !bus.host_lock;

`ifdef EDID_CSUM_EN
  localparam int unsigned BW = (P_BLOCKS > 1) ? $clog2(P_BLOCKS) : 1;

  logic [BW-1:0]   blk;
  logic            cs_rd, cs_wr, cs_last;
  logic [6:0]      cs_idx;
  logic [7:0]      cs_wval;
  logic [P_AW-1:0] cs_rd_addr, cs_wr_addr;

  assign cs_rd      = (state == S_CS_RD) && slot_free;
  assign cs_wr      = (state == S_CS_WR) && slot_free;
  assign cs_rd_addr = P_AW'(blk * EDID_BLK_BYTES + cs_idx);
  assign cs_wr_addr = P_AW'(blk * EDID_BLK_BYTES + EDID_CSUM_OFS);

  edid_csum_engine u_csum (
    .clk      (i_local_clk),
    .rst      (i_rst),
    .clear    (commit_take || cs_wr),
    .rd_issue (cs_rd),
    .rd_data  (bus.ram_rdata),
    .idx      (cs_idx),
    .last     (cs_last),
    .wr_val   (cs_wval)
  );
`else
  assign busy_q = 1'b0;
`endif

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.wp_viol   = 1'b0;
    host_grant    = 1'b0;
    if (bus.i2c_wr_de) begin
      bus.ram_addr  = bus.i2c_wr_addr;
      bus.ram_wdata = bus.i2c_wr_data;
      if (bus.wp || bus.host_lock) bus.wp_viol = 1'b1;
      else                         bus.ram_we  = 1'b1;
    end else if (bus.i2c_rd_de) begin
      bus.ram_addr = bus.i2c_rd_addr;
`ifdef EDID_CSUM_EN
    end else if (state == S_CS_RD) begin
      bus.ram_addr = cs_rd_addr;
    end else if (state == S_CS_WR) begin
      bus.ram_we    = 1'b1;
      bus.ram_addr  = cs_wr_addr;
      bus.ram_wdata = cs_wval;
`endif
    end else if (state == S_IDLE && bus.host_req) begin
      host_grant    = 1'b1;
      bus.ram_we    = bus.host_we;
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
    end
  end

  always_ff @(posedge i_local_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= S_IDLE;
      hpd    <= 1'b0;
      rvalid <= 1'b0;
      lock_q <= 1'b0;
`ifdef EDID_CSUM_EN
      busy_q <= 1'b0;
      blk    <= '0;
`endif
    end else begin
      lock_q <= bus.host_lock;
      rvalid <= host_grant && !bus.host_we;
      if (bus.host_lock && !lock_q) hpd <= 1'b0;
      case (state)
        S_IDLE: if (commit_take) begin
`ifdef EDID_CSUM_EN
          state  <= S_CS_RD;
          busy_q <= 1'b1;
          blk    <= '0;
`else
          state <= S_DONE;
          hpd   <= 1'b1;
`endif
        end
`ifdef EDID_CSUM_EN
        S_CS_RD:   if (cs_rd && cs_last) state <= S_CS_WAIT;
        S_CS_WAIT: state <= S_CS_WR;
        // hpd/busy flip on the final write edge so hpd is visible the cycle after it.
        S_CS_WR: if (cs_wr) begin
          if (blk == BW'(P_BLOCKS - 1)) begin
            state  <= S_DONE;
            hpd    <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            blk   <= blk + 1'b1;
            state <= S_CS_RD;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.i2c_rd_data = bus.ram_rdata;
  assign bus.host_rdata  = bus.ram_rdata;
  assign bus.host_ack    = host_grant;
  assign bus.host_rvalid = rvalid;
  assign bus.hpd         = hpd;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_edid_ram_arbiter.sv
// Self-checking bench for edid_ram_arbiter with a 1-cycle-latency RAM model and read scoreboards.
// Expectations follow EDID_CSUM_EN when it is defined for the build.
module tb_edid_ram_arbiter;
  localparam int unsigned AW     = 8;
  localparam int unsigned BLOCKS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  edid_ram_arbiter_if #(.P_AW(AW)) bus ();

  edid_ram_arbiter #(.P_AW(AW), .P_BLOCKS(BLOCKS)) dut (
    .i_local_clk (clk),
    .i_rst       (rst),
    .bus         (bus)
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int checks   = 0;
  int failures = 0;
  logic [7:0] shadow [256];
  logic [7:0] hq [$];
  logic [7:0] iq [$];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  task automatic idle_inputs();
    bus.i2c_wr_de = 0; bus.i2c_wr_addr = '0; bus.i2c_wr_data = '0;
    bus.i2c_rd_de = 0; bus.i2c_rd_addr = '0; bus.wp = 0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 0; bus.host_commit = 0;
  endtask

  task automatic host_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output logic got_ack, output int waited, output logic we_at_ack,
                         output logic rv, output logic [7:0] rd);
    got_ack = 0; waited = -1; we_at_ack = 0;
    @(posedge clk); #2;
    bus.host_req = 1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wdata;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (bus.host_ack) begin
        got_ack = 1; waited = n; we_at_ack = bus.ram_we;
        break;
      end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    bus.host_req = 0; bus.host_we = 0;
    @(negedge clk);
    rv = bus.host_rvalid; rd = bus.host_rdata;
  endtask

  task automatic i2c_read(input logic [7:0] addr, output logic [7:0] rd);
    @(posedge clk); #2;
    bus.i2c_rd_de = 1; bus.i2c_rd_addr = addr;
    @(posedge clk); #2;
    bus.i2c_rd_de = 0;
    @(negedge clk);
    rd = bus.i2c_rd_data;
  endtask

  function automatic logic [7:0] csum_of(input int base);
    int s = 0;
    for (int i = 0; i < 127; i++) s += int'(shadow[base + i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic run_commit(input bit inject, output int hpd_at, output int busy_cnt,
                            output logic [7:0] i2c_got);
    hpd_at = 0; busy_cnt = 0; i2c_got = '0;
    wr_addr_q.delete(); wr_data_q.delete();
    @(posedge clk); #2;
    bus.host_commit = 1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #2;
      bus.host_commit = inject && (k == 100);
      bus.i2c_rd_de   = inject && (k == 60);
      bus.i2c_rd_addr = 8'h10;
      @(negedge clk);
      if (inject && k == 61) i2c_got = bus.i2c_rd_data;
      if (bus.busy) busy_cnt++;
      if (bus.ram_we) begin
        wr_addr_q.push_back(bus.ram_addr);
        wr_data_q.push_back(bus.ram_wdata);
      end
      if (bus.hpd) begin
        hpd_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.hpd, bus.busy, bus.ram_we, bus.host_ack, bus.host_rvalid, bus.wp_viol} !== 6'b0)
      begin failures++; $display("FAIL reset_outputs: got %b required 000000",
        {bus.hpd, bus.busy, bus.ram_we, bus.host_ack, bus.host_rvalid, bus.wp_viol}); end
    @(posedge clk); #2; rst = 0;
    @(negedge clk);
    checks++;
    if (bus.hpd !== 1'b0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL post_reset_idle: hpd=%b busy=%b required 0 0", bus.hpd, bus.busy); end
  endtask

  task automatic test_host_rw();
    logic ack, wa, rv; int w; logic [7:0] rd, exp;
    host_op(1, 8'h10, 8'h5A, ack, w, wa, rv, rd);
    shadow[8'h10] = 8'h5A;
    checks++;
    if (ack !== 1'b1 || w != 0 || wa !== 1'b1 || rv !== 1'b0)
      begin failures++; $display("FAIL host_write: ack=%b wait=%0d ram_we=%b rvalid=%b required 1 0 1 0", ack, w, wa, rv); end
    hq.push_back(shadow[8'h10]);
    host_op(0, 8'h10, 8'h00, ack, w, wa, rv, rd);
    exp = hq.pop_front();
    checks++;
    if (ack !== 1'b1 || wa !== 1'b0 || rv !== 1'b1)
      begin failures++; $display("FAIL host_read_handshake: ack=%b ram_we=%b rvalid=%b required 1 0 1", ack, wa, rv); end
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL host_read_data: got %h required %h", rd, exp); end
  endtask

  task automatic test_i2c_contention();
    logic ack, wa, rv; int w; logic [7:0] rd, exp;
    hq.push_back(shadow[8'h10]);
    fork
      host_op(0, 8'h10, 8'h00, ack, w, wa, rv, rd);
      begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #2;
          bus.i2c_rd_de = 1; bus.i2c_rd_addr = 8'h10;
          iq.push_back(shadow[8'h10]);
          @(negedge clk);
          checks++;
          if (bus.host_ack !== 1'b0) begin failures++; $display("FAIL ack_withheld: cycle %0d ack=%b required 0", k, bus.host_ack); end
          if (k > 0) begin
            exp = iq.pop_front();
            checks++;
            if (bus.i2c_rd_data !== exp) begin failures++; $display("FAIL i2c_stream_data: got %h required %h", bus.i2c_rd_data, exp); end
          end
        end
        @(posedge clk); #2;
        bus.i2c_rd_de = 0;
        @(negedge clk);
        exp = iq.pop_front();
        checks++;
        if (bus.i2c_rd_data !== exp) begin failures++; $display("FAIL i2c_stream_last: got %h required %h", bus.i2c_rd_data, exp); end
      end
    join
    exp = hq.pop_front();
    checks++;
    if (ack !== 1'b1 || w != 5 || rv !== 1'b1 || rd !== exp)
      begin failures++; $display("FAIL host_after_gap: ack=%b wait=%0d rvalid=%b data=%h required 1 5 1 %h", ack, w, rv, rd, exp); end
  endtask

  task automatic test_write_protect();
    logic ack, wa, rv; int w; logic [7:0] rd, exp;
    host_op(1, 8'h20, 8'h33, ack, w, wa, rv, rd);
    shadow[8'h20] = 8'h33;
    @(posedge clk); #2;
    bus.wp = 1; bus.i2c_wr_de = 1; bus.i2c_wr_addr = 8'h20; bus.i2c_wr_data = 8'hFF;
    @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b0 || bus.wp_viol !== 1'b1)
      begin failures++; $display("FAIL wp_block: ram_we=%b wp_viol=%b required 0 1", bus.ram_we, bus.wp_viol); end
    @(posedge clk); #2;
    bus.i2c_wr_de = 0; bus.wp = 0;
    @(negedge clk);
    checks++;
    if (bus.wp_viol !== 1'b0) begin failures++; $display("FAIL wp_viol_pulse: got %b required 0", bus.wp_viol); end
    iq.push_back(shadow[8'h20]);
    i2c_read(8'h20, rd);
    exp = iq.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL wp_readback: got %h required %h", rd, exp); end
    @(posedge clk); #2;
    bus.host_lock = 1; bus.i2c_wr_de = 1; bus.i2c_wr_addr = 8'h20; bus.i2c_wr_data = 8'hEE;
    @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b0 || bus.wp_viol !== 1'b1)
      begin failures++; $display("FAIL lock_block: ram_we=%b wp_viol=%b required 0 1", bus.ram_we, bus.wp_viol); end
    @(posedge clk); #2;
    bus.host_lock = 0; bus.i2c_wr_addr = 8'h21; bus.i2c_wr_data = 8'h44;
    @(negedge clk);
    checks++;
    if (bus.ram_we !== 1'b1 || bus.wp_viol !== 1'b0)
      begin failures++; $display("FAIL i2c_write: ram_we=%b wp_viol=%b required 1 0", bus.ram_we, bus.wp_viol); end
    shadow[8'h21] = 8'h44;
    @(posedge clk); #2;
    bus.i2c_wr_de = 0;
    iq.push_back(shadow[8'h21]);
    iq.push_back(shadow[8'h20]);
    i2c_read(8'h21, rd);
    exp = iq.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL i2c_write_readback: got %h required %h", rd, exp); end
    i2c_read(8'h20, rd);
    exp = iq.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL lock_readback: got %h required %h", rd, exp); end
  endtask

  task automatic check_csum_result(input string tag, input bit inject);
    int hpd_at, busy_cnt, exp_hpd, exp_busy, exp_we; logic [7:0] ig, exp;
    logic [7:0] cs0, cs1, rd; logic ack, wa, rv; int w;
    cs0 = csum_of(0);
    cs1 = csum_of(128);
    if (inject) iq.push_back(shadow[8'h10]);
    run_commit(inject, hpd_at, busy_cnt, ig);
`ifdef EDID_CSUM_EN
    exp_hpd = 259 + int'(inject); exp_busy = 258 + int'(inject); exp_we = 2;
    shadow[127] = cs0; shadow[255] = cs1;
`else
    exp_hpd = 1; exp_busy = 0; exp_we = 0;
`endif
    checks++;
    if (hpd_at != exp_hpd) begin failures++; $display("FAIL %s_hpd_cycle: got %0d required %0d", tag, hpd_at, exp_hpd); end
    checks++;
    if (busy_cnt != exp_busy) begin failures++; $display("FAIL %s_busy_cycles: got %0d required %0d", tag, busy_cnt, exp_busy); end
    checks++;
    if (wr_addr_q.size() != exp_we) begin failures++; $display("FAIL %s_write_count: got %0d required %0d", tag, wr_addr_q.size(), exp_we); end
`ifdef EDID_CSUM_EN
    if (wr_addr_q.size() == 2) begin
      checks++;
      if (wr_addr_q[0] !== 8'd127 || wr_data_q[0] !== cs0 || wr_addr_q[1] !== 8'd255 || wr_data_q[1] !== cs1)
        begin failures++; $display("FAIL %s_csum_writes: got %h=%h %h=%h required 7f=%h ff=%h", tag,
          wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], cs0, cs1); end
    end
    if (inject) begin
      exp = iq.pop_front();
      checks++;
      if (ig !== exp) begin failures++; $display("FAIL %s_i2c_during_csum: got %h required %h", tag, ig, exp); end
    end
`else
    if (inject) iq.delete();
`endif
    foreach (cs0[i]) begin end
    hq.push_back(shadow[127]);
    hq.push_back(shadow[255]);
    host_op(0, 8'd127, 8'h00, ack, w, wa, rv, rd);
    exp = hq.pop_front();
    checks++;
    if (rv !== 1'b1 || rd !== exp) begin failures++; $display("FAIL %s_byte127: rvalid=%b got %h required %h", tag, rv, rd, exp); end
    host_op(0, 8'd255, 8'h00, ack, w, wa, rv, rd);
    exp = hq.pop_front();
    checks++;
    if (rv !== 1'b1 || rd !== exp) begin failures++; $display("FAIL %s_byte255: rvalid=%b got %h required %h", tag, rv, rd, exp); end
  endtask

  task automatic test_checksum();
    logic ack, wa, rv, ok; int w; logic [7:0] rd;
    ok = 1;
    @(posedge clk); #2; bus.host_lock = 1;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] v;
      v = (a == 127 || a == 255) ? 8'hAA : ((a < 128) ? 8'h01 : 8'h02);
      host_op(1, 8'(a), v, ack, w, wa, rv, rd);
      shadow[a] = v;
      if (ack !== 1'b1) ok = 0;
    end
    @(posedge clk); #2; bus.host_lock = 0;
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL load_acks: got %b required 1", ok); end
    check_csum_result("csum", 0);
  endtask

  task automatic test_checksum_contention();
    int bad;
    @(posedge clk); #2; bus.host_lock = 1;
    @(posedge clk); #2;
    @(negedge clk);
    checks++;
    if (bus.hpd !== 1'b0) begin failures++; $display("FAIL hpd_clear_on_lock: got %b required 0", bus.hpd); end
    @(posedge clk); #2; bus.host_commit = 1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2; bus.host_commit = 0;
      @(negedge clk);
      if (bus.hpd !== 1'b0 || bus.busy !== 1'b0 || bus.ram_we !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL commit_while_locked: active cycles %0d required 0", bad); end
    @(posedge clk); #2; bus.host_lock = 0;
    check_csum_result("csum_i2c", 1);
  endtask

  task automatic test_reset_mid();
    logic ack, wa, rv; int w, we_cnt, hpd_cnt; logic [7:0] rd, exp;
    host_op(1, 8'd127, 8'h00, ack, w, wa, rv, rd); shadow[127] = 8'h00;
    host_op(1, 8'd255, 8'h00, ack, w, wa, rv, rd); shadow[255] = 8'h00;
    @(posedge clk); #2; bus.host_lock = 1;
    @(posedge clk); #2; bus.host_lock = 0;
    @(posedge clk); #2; bus.host_commit = 1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #2; bus.host_commit = 0;
    end
`ifdef EDID_CSUM_EN
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_before_reset: got %b required 1", bus.busy); end
`endif
    rst = 1; #1;
    checks++;
    if ({bus.hpd, bus.busy, bus.ram_we, bus.host_ack, bus.host_rvalid, bus.wp_viol} !== 6'b0)
      begin failures++; $display("FAIL reset_mid_outputs: got %b required 000000",
        {bus.hpd, bus.busy, bus.ram_we, bus.host_ack, bus.host_rvalid, bus.wp_viol}); end
    repeat (2) @(posedge clk);
    #2; rst = 0;
    we_cnt = 0; hpd_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.ram_we) we_cnt++;
      if (bus.hpd) hpd_cnt++;
    end
    checks++;
    if (we_cnt != 0 || hpd_cnt != 0) begin failures++; $display("FAIL post_reset_quiet: writes=%0d hpd_cycles=%0d required 0 0", we_cnt, hpd_cnt); end
    hq.push_back(shadow[127]);
    host_op(0, 8'd127, 8'h00, ack, w, wa, rv, rd);
    exp = hq.pop_front();
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL reset_byte127: got %h required %h", rd, exp); end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_i2c_contention();
    test_write_protect();
    test_checksum();
    test_checksum_contention();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
